vga_timing_pattern_gen: RTL

Parametrised VGA timing generator with a built-in test-pattern engine, the successor to the fixed 640x480 colour-bar generator. It produces sync, data-enable, pixel coordinates and 8-bit RGB (3-3-2) for any timing set by parameters. Pattern modes are selectable at run time and applied only on frame boundaries. It sits between the pixel-clock domain and the VGA DAC pins, or in front of a framebuffer reader using `x`/`y`/`de`.

---
 rtl/vga_timing_pattern_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with run-time pattern engine (bars/checker/grid/solid); frame counter under VGA_FRAME_CNT_EN.
// Latency: every output registered, 1 dclk after the hc/vc counter state, all outputs mutually aligned.
// Backpressure: none; free-running at the pixel clock, mode/color sampled only on the frame boundary.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 29,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CW        = 10,
  parameter int CHK_LOG2  = 5,
  parameter int GRID_LOG2 = 6,
  parameter int FC_W      = 8
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic [1:0]    mode,
  input  logic [7:0]    color,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [2:0]    red,
  output logic [2:0]    green,
  output logic [1:0]    blue,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FC_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] HT_M1   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT_M1   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_C    = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_C    = CW'(V_SYNC);
  localparam logic [CW-1:0] HA0_C   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] VA0_C   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] HACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HLAST_C = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] VLAST_C = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] BW_M1   = CW'(H_ACTIVE / 8 - 1);

  logic [CW-1:0] hc, vc, hc_nxt, vc_nxt;
  logic [CW-1:0] bar_cnt;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;
  logic [7:0]    color_q;
  logic          h_end, v_end, frame_end;

  logic [CW-1:0] xa, ya, xc, yc;
  logic          h_act, v_act, de_c, hs_c, vs_c;
  logic [7:0]    pix, rgb_c;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hFC;
      3'd2:    c = 8'h1F;
      3'd3:    c = 8'h1C;
      3'd4:    c = 8'hE3;
      3'd5:    c = 8'hE0;
      3'd6:    c = 8'h03;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    h_end     = (hc == HT_M1);
    v_end     = (vc == VT_M1);
    frame_end = h_end && v_end;
    hc_nxt    = h_end ? '0 : hc + 1'b1;
    vc_nxt    = vc;
    if (h_end) begin
      vc_nxt = v_end ? '0 : vc + 1'b1;
    end
  end

  // Bar sub-counter tracks the current hc; it is cleared on the edge that moves hc onto x = 0.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hc      <= '0;
      vc      <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode_q  <= '0;
      color_q <= '0;
    end else begin
      hc <= hc_nxt;
      vc <= vc_nxt;
      if (hc_nxt == HA0_C) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BW_M1) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
      if (frame_end) begin
        mode_q  <= mode;
        color_q <= color;
      end
    end
  end

  always_comb begin
    xa    = hc - HA0_C;
    ya    = vc - VA0_C;
    h_act = (hc >= HA0_C) && (xa < HACT_C);
    v_act = (vc >= VA0_C) && (ya < VACT_C);
    de_c  = h_act && v_act;
    xc    = de_c ? xa : '0;
    yc    = de_c ? ya : '0;
    hs_c  = (hc < HS_C) ? H_POL : ~H_POL;
    vs_c  = (vc < VS_C) ? V_POL : ~V_POL;

    pix = 8'h00;
    unique case (mode_q)
      2'd0: pix = bar_color(bar_idx);
      2'd1: pix = (xc[CHK_LOG2] ^ yc[CHK_LOG2]) ? 8'hFF : 8'h00;
      2'd2: pix = ((xc[GRID_LOG2-1:0] == '0) || (yc[GRID_LOG2-1:0] == '0) ||
                   (xc == HLAST_C) || (yc == VLAST_C)) ? 8'hFF : 8'h00;
      default: pix = color_q;
    endcase
    rgb_c = de_c ? pix : 8'h00;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_c;
      vsync       <= vs_c;
      de          <= de_c;
      x           <= xc;
      y           <= yc;
      red         <= rgb_c[7:5];
      green       <= rgb_c[4:2];
      blue        <= rgb_c[1:0];
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Internal count steps on the boundary; the port copy lags one cycle so it changes with frame_start.
  logic [FC_W-1:0] fc;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      fc        <= '0;
      frame_cnt <= '0;
    end else begin
      if (frame_end) begin
        fc <= fc + 1'b1;
      end
      frame_cnt <= fc;
    end
  end
`endif

endmodule
